// File: rtl/pid_mc.sv
// Time-multiplexed multi-channel PID controller: one shared MAC datapath,
// per-channel gain/integrator/previous-error banks, 4-cycle sample pipeline.
module pid_mc #(
    parameter int W       = 16,
    parameter int NUM_CH  = 4,
    parameter int FRAC    = 8,
    parameter int MAX_VAL = 32767,
    parameter int MIN_VAL = -32768,
    localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [CW-1:0]       sample_ch,
    input  logic signed [W-1:0] setpoint,
    input  logic signed [W-1:0] sensor_measurement,
    input  logic                int_hold,
    input  logic                clr_valid,
    input  logic [CW-1:0]       clr_ch,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [1:0]          cfg_sel,
    input  logic signed [W-1:0] cfg_data,
    output logic                out_valid,
    output logic [CW-1:0]       out_ch,
    output logic signed [W-1:0] y_out,
    output logic                sat
);
    localparam int AW = 2*W + 4;
    localparam logic signed [AW-1:0] Y_MAX = AW'(MAX_VAL);
    localparam logic signed [AW-1:0] Y_MIN = AW'(MIN_VAL);
    localparam logic signed [AW-1:0] I_MAX = Y_MAX <<< FRAC;
    localparam logic signed [AW-1:0] I_MIN = Y_MIN <<< FRAC;
    localparam logic [CW:0]          NCH   = (CW+1)'(NUM_CH);

    typedef enum logic [1:0] {IDLE, ERR, MUL, OUT} state_t;
    state_t state, state_nx;

    logic signed [W-1:0]  kp_bank [NUM_CH];
    logic signed [W-1:0]  ki_bank [NUM_CH];
    logic signed [W-1:0]  kd_bank [NUM_CH];
    logic signed [AW-1:0] i_bank  [NUM_CH];
    logic signed [W:0]    ep_bank [NUM_CH];

    logic [CW-1:0]        ch_r, ci, s_idx;
    logic                 ok_r, hold_r, s_ok, accept, wr_ok, clr_ok;
    logic signed [W-1:0]  sp_r, pv_r, kp_r, ki_r, kd_r;
    logic signed [W:0]    e_c, e_r;
    logic signed [W+1:0]  de_r;
    logic signed [AW-1:0] p_r, d_r, i_r, i_sum, i_clamp, sum_c, s_c;
    logic signed [W-1:0]  y_c;
    logic                 sat_c;

    assign sample_ready = (state == IDLE) && !reset;
    assign accept       = sample_valid && sample_ready;
    assign s_ok         = {1'b0, sample_ch} < NCH;
    assign s_idx        = s_ok ? sample_ch : '0;
    assign ci           = ok_r ? ch_r : '0;
    assign wr_ok        = cfg_we && (cfg_sel != 2'd3) && ({1'b0, cfg_ch} < NCH);
    assign clr_ok       = clr_valid && ({1'b0, clr_ch} < NCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_valid) state_nx = ERR;
            ERR:     state_nx = MUL;
            MUL:     state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        e_c   = (W+1)'(sp_r) - (W+1)'(pv_r);
        i_sum = i_bank[ci] + AW'(ki_r) * AW'(e_r);
        if (i_sum > I_MAX)      i_clamp = I_MAX;
        else if (i_sum < I_MIN) i_clamp = I_MIN;
        else                    i_clamp = i_sum;
        sum_c = p_r + i_r + d_r;
        s_c   = sum_c >>> FRAC;
        sat_c = 1'b1;
        if (s_c > Y_MAX)      y_c = W'(MAX_VAL);
        else if (s_c < Y_MIN) y_c = W'(MIN_VAL);
        else begin
            y_c   = s_c[W-1:0];
            sat_c = 1'b0;
        end
    end

    // Gains are snapshotted at accept so later cfg writes cannot disturb an in-flight sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_r <= '0; ok_r <= 1'b0; hold_r <= 1'b0;
            sp_r <= '0; pv_r <= '0; kp_r <= '0; ki_r <= '0; kd_r <= '0;
            e_r  <= '0; de_r <= '0; p_r <= '0; d_r <= '0; i_r <= '0;
        end else begin
            if (accept) begin
                ch_r   <= sample_ch;
                ok_r   <= s_ok;
                hold_r <= int_hold;
                sp_r   <= setpoint;
                pv_r   <= sensor_measurement;
                kp_r   <= kp_bank[s_idx];
                ki_r   <= ki_bank[s_idx];
                kd_r   <= kd_bank[s_idx];
            end
            if (state == ERR) begin
                e_r  <= e_c;
                de_r <= (W+2)'(e_c) - (W+2)'(ep_bank[ci]);
            end
            if (state == MUL) begin
                p_r <= AW'(kp_r) * AW'(e_r);
                d_r <= AW'(kd_r) * AW'(de_r);
                i_r <= hold_r ? i_bank[ci] : i_clamp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            y_out     <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= (state == OUT) && ok_r;
            if ((state == OUT) && ok_r) begin
                out_ch <= ch_r;
                y_out  <= y_c;
                sat    <= sat_c;
            end
        end
    end

    // Clear is written last so it overrides a same-cycle commit to the same channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                kp_bank[i] <= '0;
                ki_bank[i] <= '0;
                kd_bank[i] <= '0;
                i_bank[i]  <= '0;
                ep_bank[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                case (cfg_sel)
                    2'd0:    kp_bank[cfg_ch] <= cfg_data;
                    2'd1:    ki_bank[cfg_ch] <= cfg_data;
                    2'd2:    kd_bank[cfg_ch] <= cfg_data;
                    default: ;
                endcase
            end
            if ((state == OUT) && ok_r) begin
                i_bank[ch_r]  <= i_r;
                ep_bank[ch_r] <= e_r;
            end
            if (clr_ok) begin
                i_bank[clr_ch]  <= '0;
                ep_bank[clr_ch] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pid_mc.sv
// Scoreboard bench for pid_mc: directed plan cases plus random traffic,
// checked against a plain-arithmetic PID model.
module tb_pid_mc;
    localparam int W = 16, NUM_CH = 4, FRAC = 8, CW = 2;
    localparam int MAXV = 32767, MINV = -32768;

    logic clk, reset, sample_valid, sample_ready, int_hold, clr_valid, cfg_we;
    logic out_valid, sat;
    logic [CW-1:0] sample_ch, clr_ch, cfg_ch, out_ch;
    logic [1:0] cfg_sel;
    logic signed [W-1:0] setpoint, sensor_measurement, cfg_data, y_out;

    pid_mc #(.W(W), .NUM_CH(NUM_CH), .FRAC(FRAC), .MAX_VAL(MAXV), .MIN_VAL(MINV)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_ch(sample_ch), .setpoint(setpoint), .sensor_measurement(sensor_measurement),
        .int_hold(int_hold), .clr_valid(clr_valid), .clr_ch(clr_ch), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .out_valid(out_valid),
        .out_ch(out_ch), .y_out(y_out), .sat(sat));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int ch; longint y; bit sat; int cyc; } exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0, cyc = 0;

    longint mkp[NUM_CH], mki[NUM_CH], mkd[NUM_CH], mi[NUM_CH], mep[NUM_CH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, longint act, longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    exp_t got;
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out_valid: got ch=%0d y=%0d, expected no output",
                         out_ch, $signed(y_out));
            end else begin
                got = sb.pop_front();
                check("out_ch", longint'(out_ch), longint'(got.ch));
                check("y_out", longint'($signed(y_out)), got.y);
                check("sat", longint'(sat), longint'(got.sat));
                check("latency", longint'(cyc), longint'(got.cyc));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            mkp[i] = 0; mki[i] = 0; mkd[i] = 0; mi[i] = 0; mep[i] = 0;
        end
    endtask

    task automatic wr_gain(int ch, int sel, int val);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = 2'(sel); cfg_data = W'(val);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (ch < NUM_CH) begin
            if (sel == 0) mkp[ch] = val;
            else if (sel == 1) mki[ch] = val;
            else if (sel == 2) mkd[ch] = val;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!sample_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic clear_ch(int ch);
        wait_idle();
        clr_valid = 1'b1; clr_ch = CW'(ch);
        @(posedge clk); #1;
        clr_valid = 1'b0;
        mi[ch] = 0; mep[ch] = 0;
    endtask

    // PID law evaluated on whole numbers; floor division by 2^FRAC.
    task automatic issue(int ch, int sp, int pv, bit hold, bit expect_out = 1'b1);
        longint e, de, iv, tot, s, lo, hi;
        exp_t x;
        wait_idle();
        sample_ch = CW'(ch); setpoint = W'(sp); sensor_measurement = W'(pv);
        int_hold = hold; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        if (expect_out && ch < NUM_CH) begin
            lo = longint'(MINV) * (longint'(1) << FRAC);
            hi = longint'(MAXV) * (longint'(1) << FRAC);
            e  = longint'(sp) - longint'(pv);
            de = e - mep[ch];
            iv = mi[ch] + mki[ch] * e;
            if (iv > hi) iv = hi;
            if (iv < lo) iv = lo;
            if (hold) iv = mi[ch];
            tot = mkp[ch] * e + iv + mkd[ch] * de;
            s = tot / 256;
            if (tot < 0 && (tot % 256) != 0) s = s - 1;
            x.ch = ch; x.cyc = cyc + 3;
            x.sat = (s > MAXV) || (s < MINV);
            x.y = (s > MAXV) ? MAXV : (s < MINV) ? MINV : s;
            sb.push_back(x);
            mi[ch] = iv; mep[ch] = e;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; sample_valid = 1'b0; int_hold = 1'b0; clr_valid = 1'b0; cfg_we = 1'b0;
        sample_ch = '0; clr_ch = '0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        setpoint = '0; sensor_measurement = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", longint'(sample_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y_out", longint'($signed(y_out)), 0);
        check("rst_sat", longint'(sat), 0);
        check("rst_out_ch", longint'(out_ch), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", longint'(sample_ready), 1);

        wr_gain(0, 0, 256);
        issue(0, 1000, 0, 0);                         // 1000

        wr_gain(1, 1, 128);
        repeat (5) issue(1, 100, 0, 0);               // 50..250
        issue(1, 100, 0, 1);                          // held: 250
        clear_ch(1);
        issue(1, 100, 0, 0);                          // 50
        issue(1, 300, 200, 0);                        // 100, then clear at OUT
        @(negedge clk); @(negedge clk); @(negedge clk);
        clr_valid = 1'b1; clr_ch = 2'd1;
        @(posedge clk); #1;
        clr_valid = 1'b0;
        mi[1] = 0; mep[1] = 0;
        issue(1, 100, 0, 0);                          // clear won: 50

        wr_gain(0, 0, 10240);
        issue(0, 1000, 0, 0);                         // 32767 sat
        issue(0, -1000, 0, 0);                        // -32768 sat

        wr_gain(0, 0, 0);
        wr_gain(0, 1, 256);
        clear_ch(0);
        repeat (3) issue(0, 30000, 0, 0);             // 30000, 32767, 32767
        issue(0, -1000, 0, 0);                        // 31767

        wr_gain(2, 2, 256);
        wr_gain(3, 0, 256);
        issue(2, 0, 0, 0);    issue(3, 7, 0, 0);
        issue(2, 100, 0, 0);  issue(3, 10, 3, 0);
        issue(2, 100, 0, 0);  issue(3, 7, 0, 0);
        issue(2, 40, 0, 0);   issue(3, 0, -7, 0);

        wr_gain(3, 0, 512);
        issue(3, 100, 0, 0);                          // old gain latched
        wr_gain(3, 0, 256);                           // write while in flight
        issue(3, 100, 0, 0);                          // new gain

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    wr_gain($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2048) - 1024);
                else
                    wr_gain($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535) - 32768);
            end
            if ($urandom_range(0, 9) == 0) clear_ch($urandom_range(0, 3));
            issue($urandom_range(0, 3), $urandom_range(0, 65535) - 32768,
                  $urandom_range(0, 65535) - 32768, $urandom_range(0, 4) == 0);
        end

        issue(0, 500, 0, 0, 1'b0);                    // aborted by reset in MUL
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_y_out", longint'($signed(y_out)), 0);
        check("abort_sat", longint'(sat), 0);
        check("abort_out_ch", longint'(out_ch), 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(0, 500, 0, 0);                          // gains cleared: 0

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_pending", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pid_mc.md
Name: pid_mc

Overview:
- Multi-channel, time-multiplexed PID controller: one shared multiply/accumulate datapath serves NUM_CH independent loops.
- Per-channel gains, integrator and previous-error state are held in internal register banks.
- Replaces the single-loop PID core in motor/plant control paths.
- Adds runtime-writable gains, fixed-point gain scaling, integrator anti-windup clamp, integrator hold and per-channel clear, valid/ready sample handshake, and a saturation flag.

Parameters:
- W, 16: signed data width of setpoint, measurement, gains and output.
- NUM_CH, 4: number of control channels (>=1).
- FRAC, 8: fractional bits of gains (Q(W-FRAC).FRAC).
- MAX_VAL, 32767: output upper saturation limit.
- MIN_VAL, -32768: output lower saturation limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  sample request.
- sample_ready  out  1  core idle; can accept a sample.
- sample_ch  in  CW  target channel; CW = max(1, clog2(NUM_CH)).
- setpoint  in  W  signed setpoint.
- sensor_measurement  in  W  signed process value.
- int_hold  in  1  when 1, the integrator of the sampled channel is not updated.
- clr_valid  in  1  clear request for one channel's integrator and previous error.
- clr_ch  in  CW  channel to clear.
- cfg_we  in  1  gain write strobe.
- cfg_ch  in  CW  gain write channel.
- cfg_sel  in  2  gain select: 0=Kp, 1=Ki, 2=Kd, 3=ignored.
- cfg_data  in  W  signed gain value.
- out_valid  out  1  one-cycle result strobe.
- out_ch  out  CW  channel of result.
- y_out  out  W  signed saturated control output.
- sat  out  1  y_out was clamped (valid with out_valid).

Behaviour:
- Reset (async, asserted): FSM to IDLE; sample_ready=0, out_valid=0, out_ch=0, y_out=0, sat=0; all gains, integrators and e_prev cleared. sample_ready=1 in the first cycle after deassertion. Reset mid-operation aborts the sample: no out_valid, no state commit.
- FSM: IDLE -> ERR -> MUL -> OUT -> IDLE.
  - sample_ready = (state==IDLE).
  - Sample accepted on the clk edge where sample_valid && sample_ready. Inputs, int_hold and the channel's gains are latched at that edge.
- ERR: e = setpoint - sensor_measurement, W+1 bits signed; de = e - e_prev[ch], W+2 bits.
- MUL:
  - P = Kp*e; D = Kd*de.
  - I' = I[ch] + Ki*e, clamped to [MIN_VAL<<FRAC, MAX_VAL<<FRAC]. I' = I[ch] if int_hold.
  - All products are full precision; accumulator width >= 2W+3.
- OUT:
  - s = (P + I' + D) >>> FRAC (arithmetic shift, floor).
  - y_out = clamp(s, MIN_VAL, MAX_VAL); sat=1 iff clamped.
  - out_valid=1 for exactly this cycle; out_ch = channel.
  - I[ch] <= I', e_prev[ch] <= e committed at this cycle's edge.
  - y_out, out_ch and sat hold their value until the next OUT.
- Latency: accept at edge k -> out_valid high in the cycle following edge k+3. Throughput is 1 sample / 4 cycles.
- Channel >= NUM_CH: accepted, traversed with no state commit, no out_valid, y_out unchanged.
- Gain writes: accepted any cycle; take effect from the next accepted sample. An in-flight sample uses latched gains. cfg_sel=3 or cfg_ch>=NUM_CH is ignored.
- clr_valid: zeroes I[clr_ch] and e_prev[clr_ch] at the edge. If it coincides with the OUT commit for the same channel, the clear wins; the emitted y_out is still the computed value.
- Channels are fully independent; no state leaks between channels.

Test Plan:
- Reset, then Kp=256 (1.0), Ki=Kd=0 on ch0; sp=1000, pv=0 -> out_valid 4 cycles after accept, out_ch=0, y_out=1000, sat=0.
- Ki=128 (0.5) on ch1, Kp=Kd=0; five samples with e=100 -> y_out 50,100,150,200,250. Then one sample with int_hold=1 -> 250. Then clr_valid ch1, sample e=100 -> 50.
- Kp=10240 (40.0), e=1000 -> y_out=32767, sat=1; e=-1000 -> y_out=-32768, sat=1.
- Anti-windup: Ki=256, e=30000 for 3 samples -> y_out 30000, 32767, 32767. Then e=-1000 -> y_out=31767 (integrator clamped, not wound up).
- Derivative: Kd=256 on ch2, e sequence 0,100,100,40 -> y_out 0,100,0,-60. Interleave ch3 samples (Kp=256, e=7) between them -> ch3 always 7, ch2 sequence unchanged.
- Gain write to an in-flight channel -> current output uses old gain, next uses new. sample_ch=NUM_CH (when NUM_CH not a power of two) -> no out_valid. Reset asserted in MUL -> no out_valid, all outputs 0.
